// File: rtl/iter_muldiv_unit.sv
// iter_muldiv_unit
// Iterative multiply / divide unit for the multicycle core. Runs MUL, MLA,
// UDIV and SDIV over several cycles behind a start/busy/done handshake.
//
// Parameters:
//   WIDTH  - operand/result width (even, >= 8)
//   UNROLL - bits retired per RUN cycle (1, 2 or 4; divides WIDTH)
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   start      request, accepted only in IDLE
//   flush      synchronous abort back to IDLE, no done pulse
//   op         00 MUL, 01 MLA, 10 UDIV, 11 SDIV (sampled at accept)
//   a, b, acc  operands (sampled at accept)
//   busy       high while an accepted op is in flight
//   done       one-cycle pulse, result/remainder/dz/nz valid
//   result     product low word or quotient (held until next completion)
//   remainder  divide remainder, 0 for MUL/MLA
//   dz         divide by zero on the last op
//   nz         {N,Z} flags of result
//
// Optional build macro:
//   MULDIV_EARLY_OUT_EN - MUL/MLA leave RUN as soon as the remaining
//                         multiplier bits are all zero.

module iter_muldiv_unit #(
    parameter int WIDTH  = 32,
    parameter int UNROLL = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] acc,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             dz,
    output logic [1:0]       nz
);

    localparam int STEPS = WIDTH / UNROLL;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_MLA  = 2'b01;
    localparam logic [1:0] OP_SDIV = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] prod;
        logic [WIDTH-1:0] mcand;
        logic [WIDTH-1:0] mplier;
    } mul_t;

    typedef struct packed {
        logic [WIDTH:0]   rem;
        logic [WIDTH-1:0] quo;
    } div_t;

    // Shift-add over UNROLL multiplier bits; only the low WIDTH bits survive.
    function automatic mul_t mul_step(input mul_t s);
        mul_t r;
        r = s;
        for (int i = 0; i < UNROLL; i++) begin
            if (r.mplier[0]) r.prod = r.prod + r.mcand;
            r.mcand  = r.mcand << 1;
            r.mplier = r.mplier >> 1;
        end
        return r;
    endfunction

    // Restoring shift-subtract over UNROLL dividend bits. The partial
    // remainder carries one extra bit so the compare never overflows.
    function automatic div_t div_step(input div_t s, input logic [WIDTH-1:0] d);
        div_t r;
        r = s;
        for (int i = 0; i < UNROLL; i++) begin
            r.rem = {r.rem[WIDTH-1:0], r.quo[WIDTH-1]};
            r.quo = r.quo << 1;
            if (r.rem >= {1'b0, d}) begin
                r.rem    = r.rem - {1'b0, d};
                r.quo[0] = 1'b1;
            end
        end
        return r;
    endfunction

    // Magnitude of a value that may be two's complement; the most-negative
    // value maps onto itself, which is the correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v,
                                             input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? (-v) : v;
    endfunction

    state_t           state, next_state;
    logic [CW-1:0]    cnt;
    logic             early;

    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] acc_q;
    logic             neg_q;
    logic             rneg_q;
    logic             dz_q;
    logic [WIDTH-1:0] prod_q;
    logic [WIDTH-1:0] mcand_q;   // multiplicand, or divisor magnitude
    logic [WIDTH-1:0] work_q;    // multiplier, or dividend shifting into quotient
    logic [WIDTH:0]   rem_q;

    mul_t             mul_nx;
    div_t             div_nx;
    logic [WIDTH-1:0] fin_res;
    logic [WIDTH-1:0] fin_rem;
    logic             accept;
    logic             acc_is_sdiv;

    assign accept      = (state == S_IDLE) && start && !flush;
    assign acc_is_sdiv = (op == OP_SDIV);

`ifdef MULDIV_EARLY_OUT_EN
    assign early = !op_q[1] && ((work_q >> UNROLL) == '0);
`else
    assign early = 1'b0;
`endif

    // ---- control: state register ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state == S_RUN) || (next_state == S_FIX);
            done  <= (next_state == S_DONE);
            if (accept)
                cnt <= '0;
            else if (state == S_RUN)
                cnt <= cnt + CW'(1);
        end
    end

    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (start) next_state = (op[1] && (b == '0)) ? S_FIX : S_RUN;
                S_RUN:  if (cnt == LAST || early) next_state = S_FIX;
                S_FIX:  next_state = S_DONE;
                S_DONE: next_state = S_IDLE;
                default: next_state = S_IDLE;
            endcase
        end
    end

    // ---- datapath: operand capture and iteration ----
    always_comb begin
        mul_nx = mul_step({prod_q, mcand_q, work_q});
        div_nx = div_step({rem_q, work_q}, mcand_q);
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_q    <= op;
            a_q     <= a;
            acc_q   <= acc;
            neg_q   <= acc_is_sdiv && (a[WIDTH-1] ^ b[WIDTH-1]);
            rneg_q  <= acc_is_sdiv && a[WIDTH-1];
            dz_q    <= op[1] && (b == '0);
            prod_q  <= '0;
            rem_q   <= '0;
            mcand_q <= op[1] ? mag(b, acc_is_sdiv) : a;
            work_q  <= op[1] ? mag(a, acc_is_sdiv) : b;
        end else if (state == S_RUN) begin
            if (!op_q[1]) begin
                prod_q  <= mul_nx.prod;
                mcand_q <= mul_nx.mcand;
                work_q  <= mul_nx.mplier;
            end else begin
                rem_q   <= div_nx.rem;
                work_q  <= div_nx.quo;
            end
        end
    end

    // ---- fix-up: accumulate, sign correction, divide-by-zero ----
    always_comb begin
        fin_res = '0;
        fin_rem = '0;
        if (dz_q) begin
            fin_res = '0;
            fin_rem = a_q;
        end else if (op_q == OP_MUL) begin
            fin_res = prod_q;
        end else if (op_q == OP_MLA) begin
            fin_res = prod_q + acc_q;
        end else begin
            fin_res = neg_q  ? (-work_q) : work_q;
            fin_rem = rneg_q ? (-rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];
        end
    end

    // ---- output registers: update on entry to DONE ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result    <= '0;
            remainder <= '0;
            dz        <= 1'b0;
            nz        <= 2'b01;
        end else if (state == S_FIX && !flush) begin
            result    <= fin_res;
            remainder <= fin_rem;
            dz        <= dz_q;
            nz        <= {fin_res[WIDTH-1], (fin_res == '0)};
        end
    end

endmodule

// File: tb/tb_iter_muldiv_unit.sv
// Directed bench for iter_muldiv_unit at WIDTH=32, UNROLL=1.
module tb_iter_muldiv_unit;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         start;
    logic         flush;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] acc;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [W-1:0] remainder;
    logic         dz;
    logic [1:0]   nz;

    int total = 0;
    int bad   = 0;

    iter_muldiv_unit #(.WIDTH(W), .UNROLL(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .flush     (flush),
        .op        (op),
        .a         (a),
        .b         (b),
        .acc       (acc),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .remainder (remainder),
        .dz        (dz),
        .nz        (nz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a request on a negedge; it is accepted on the following posedge.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [W-1:0] z);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y; acc = z;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Count cycles after accept until done is seen (bounded).
    task automatic wait_done(output int lat, output int bc);
        lat = 0;
        bc  = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            lat++;
            if (busy === 1'b1) bc++;
            if (done === 1'b1) break;
        end
    endtask

    initial begin
        int lat;
        int bc;
        int dn;

        reset = 1'b0; start = 1'b0; flush = 1'b0;
        op = 2'b00; a = '0; b = '0; acc = '0;

        // reset values
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_dz", dz, 1'b0);
        check("rst_result", result, 32'h0);
        check("rst_rem", remainder, 32'h0);
        check("rst_nz", nz, 2'b01);
        reset = 1'b1;

        // MUL 7*6
        issue(2'b00, 32'd7, 32'd6, 32'd0);
        wait_done(lat, bc);
        check("mul_done_seen", done, 1'b1);
        check("mul_latency", lat, 34);
        check("mul_busy_cycles", bc, 33);
        check("mul_result", result, 32'd42);
        check("mul_rem", remainder, 32'd0);
        check("mul_nz", nz, 2'b00);
        check("mul_dz", dz, 1'b0);
        @(negedge clk);
        check("mul_done_pulse", done, 1'b0);
        check("mul_result_held", result, 32'd42);

        // MLA wraps modulo 2^32
        issue(2'b01, 32'hFFFFFFFF, 32'd2, 32'd5);
        wait_done(lat, bc);
        check("mla_done_seen", done, 1'b1);
        check("mla_result", result, 32'h00000003);
        check("mla_nz", nz, 2'b00);

        // UDIV 100/7
        issue(2'b10, 32'd100, 32'd7, 32'd0);
        wait_done(lat, bc);
        check("udiv_latency", lat, 34);
        check("udiv_result", result, 32'd14);
        check("udiv_rem", remainder, 32'd2);

        // SDIV -100/7
        issue(2'b11, 32'hFFFFFF9C, 32'd7, 32'd0);
        wait_done(lat, bc);
        check("sdiv_result", result, 32'hFFFFFFF2);
        check("sdiv_rem", remainder, 32'hFFFFFFFE);
        check("sdiv_nz", nz, 2'b10);

        // divide by zero
        issue(2'b10, 32'd55, 32'd0, 32'd0);
        wait_done(lat, bc);
        check("dz_latency", lat, 2);
        check("dz_result", result, 32'd0);
        check("dz_rem", remainder, 32'd55);
        check("dz_flag", dz, 1'b1);
        check("dz_nz", nz, 2'b01);

        // most-negative / -1
        issue(2'b11, 32'h80000000, 32'hFFFFFFFF, 32'd0);
        wait_done(lat, bc);
        check("sdiv_min_result", result, 32'h80000000);
        check("sdiv_min_rem", remainder, 32'd0);
        check("sdiv_min_dz", dz, 1'b0);

        // start while busy is ignored
        issue(2'b00, 32'd5, 32'd5, 32'd0);
        repeat (4) @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'd100; b = 32'd100;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, bc);
        check("ign_done_seen", done, 1'b1);
        check("ign_result", result, 32'd25);

        // reset mid-RUN
        issue(2'b00, 32'd7, 32'd7, 32'd0);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_result", result, 32'd0);
        check("midrst_nz", nz, 2'b01);
        @(negedge clk);
        reset = 1'b1;
        dn = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) dn++;
        end
        check("midrst_no_done", dn, 0);

        // flush at RUN cycle 10
        issue(2'b00, 32'd4, 32'd4, 32'd0);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush_busy", busy, 1'b0);
        check("flush_done", done, 1'b0);
        dn = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) dn++;
        end
        check("flush_no_done", dn, 0);
        check("flush_result_kept", result, 32'd0);

        issue(2'b00, 32'd3, 32'd3, 32'd0);
        wait_done(lat, bc);
        check("post_flush_result", result, 32'd9);

        // MUL 9*3: early-out shortens latency when enabled
        issue(2'b00, 32'd9, 32'd3, 32'd0);
        wait_done(lat, bc);
`ifdef MULDIV_EARLY_OUT_EN
        check("mul93_latency", lat, 4);
`else
        check("mul93_latency", lat, 34);
`endif
        check("mul93_result", result, 32'd27);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
